pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_ctrl_stall_prio_enc.sv | 24 ++
 rtl/pipe_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and stall patterns for the pipeline controller.
// Also provides STALL_WIDTH / MEM_ADDR_WIDTH when no core-wide defines were loaded.
`ifndef STALL_WIDTH
`define STALL_WIDTH 6
`endif
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif

package pipe_ctrl_pkg;

  localparam int STALL_W = `STALL_WIDTH;
  localparam int ADDR_W  = `MEM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } ctrl_state_e;

  // Bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

endpackage

// File: rtl/pipe_ctrl_stall_prio_enc.sv
// Combinational priority encoder: the latest stalling stage wins and freezes
// everything upstream of it. mask_id_i suppresses the ID load-use request.
module stall_prio_enc
  import pipe_ctrl_pkg::*;
(
  input  logic               req_id_i,
  input  logic               req_ex_i,
  input  logic               req_mem_i,
  input  logic               mask_id_i,
  output logic [STALL_W-1:0] stall_o
);

  always_comb begin
    stall_o = STALL_NONE;
    if (req_mem_i) begin
      stall_o = STALL_MEM;
    end else if (req_ex_i) begin
      stall_o = STALL_EX;
    end else if (req_id_i && !mask_id_i) begin
      stall_o = STALL_ID;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests, sequences branch redirects
// (deferred under EX/MEM stalls) and holds the core frozen for a boot window.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stallreq_id,
  input  logic                       stallreq_ex,
  input  logic                       stallreq_mem,
  input  logic                       branch_taken_ex,
  input  logic [`MEM_ADDR_WIDTH-1:0] branch_addr_ex,
  output logic [`STALL_WIDTH-1:0]    stall,
  output logic                       flush,
  output logic                       branch_taken,
  output logic [`MEM_ADDR_WIDTH-1:0] branch_addr,
  output logic                       busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]       perf_stall_cycles,
  output logic [CNT_WIDTH-1:0]       perf_flush_cnt
`endif
);

  ctrl_state_e         state_q, state_d;
  logic [3:0]          boot_cnt_q, boot_cnt_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [STALL_W-1:0]  enc_stall;
  logic                mask_id;
  logic                hold;

  assign hold    = stallreq_mem | stallreq_ex;
  // A redirect (immediate or pending) flushes ID, so its load-use hazard is moot.
  assign mask_id = (state_q == PEND) || ((state_q == RUN) && branch_taken_ex);

  stall_prio_enc u_prio (
    .req_id_i  (stallreq_id),
    .req_ex_i  (stallreq_ex),
    .req_mem_i (stallreq_mem),
    .mask_id_i (mask_id),
    .stall_o   (enc_stall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      boot_cnt_q  <= '0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    pend_addr_d  = pend_addr_q;
    stall        = STALL_NONE;
    flush        = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    busy         = 1'b0;
    unique case (state_q)
      BOOT: begin
        stall      = STALL_ALL;
        busy       = 1'b1;
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q == 4'(BOOT_CYCLES - 1)) begin
          boot_cnt_d = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        stall = enc_stall;
        if (branch_taken_ex) begin
          if (!hold) begin
            branch_taken = 1'b1;
            branch_addr  = branch_addr_ex;
            flush        = 1'b1;
          end else begin
            pend_addr_d = branch_addr_ex;
            busy        = 1'b1;
            state_d     = PEND;
          end
        end
      end
      PEND: begin
        // Further branch pulses here are protocol errors; the first target wins.
        stall = enc_stall;
        busy  = 1'b1;
        if (!hold) begin
          branch_taken = 1'b1;
          branch_addr  = pend_addr_q;
          flush        = 1'b1;
          state_d      = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    if (rst) begin
      stall        = STALL_NONE;
      flush        = 1'b0;
      branch_taken = 1'b0;
      branch_addr  = '0;
      busy         = 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_WIDTH-1:0] stall_cyc_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((state_q != BOOT) && stall[0] && !(&stall_cyc_q)) begin
        stall_cyc_q <= stall_cyc_q + 1'b1;
      end
      if (flush && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign perf_stall_cycles = stall_cyc_q;
  assign perf_flush_cnt    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed plan sequences followed by random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int BOOT  = 4;
  localparam int CNT_W = 16;
  localparam int EXP_W = STALL_W + 3 + ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stallreq_id = 1'b0;
  logic              stallreq_ex = 1'b0;
  logic              stallreq_mem = 1'b0;
  logic              branch_taken_ex = 1'b0;
  logic [ADDR_W-1:0] branch_addr_ex = '0;
  logic [STALL_W-1:0] stall;
  logic              flush;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_addr;
  logic              busy;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0]  perf_stall_cycles;
  logic [CNT_W-1:0]  perf_flush_cnt;
`endif

  pipe_ctrl #(.BOOT_CYCLES(BOOT), .CNT_WIDTH(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_id     (stallreq_id),
    .stallreq_ex     (stallreq_ex),
    .stallreq_mem    (stallreq_mem),
    .branch_taken_ex (branch_taken_ex),
    .branch_addr_ex  (branch_addr_ex),
    .stall           (stall),
    .flush           (flush),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .busy            (busy)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_cnt    (perf_flush_cnt)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  logic [EXP_W-1:0]  exp_q[$];
  int                tests = 0;
  int                fails = 0;

  // Reference model state
  int                boot_left = 0;
  logic [ADDR_W-1:0] pend_q[$];
  int                m_stall_cycles = 0;
  int                m_flush_cnt = 0;

  // Apply one cycle of inputs and push the outputs the model expects for it.
  task automatic cyc(input logic r, input logic id, input logic ex, input logic mem,
                     input logic bt, input logic [ADDR_W-1:0] addr);
    logic [STALL_W-1:0] e_stall;
    logic               e_flush, e_bt, e_busy;
    logic [ADDR_W-1:0]  e_addr;
    int                 depth;
    logic               redirect_masks_id;
    @(posedge clk);
    #1;
    rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    branch_taken_ex = bt; branch_addr_ex = addr;
    e_stall = '0; e_flush = 1'b0; e_bt = 1'b0; e_busy = 1'b0; e_addr = '0;
    if (r) begin
      boot_left = BOOT;
      pend_q.delete();
      m_stall_cycles = 0;
      m_flush_cnt = 0;
    end else if (boot_left > 0) begin
      e_stall = '1;
      e_busy = 1'b1;
      boot_left--;
    end else begin
      redirect_masks_id = (pend_q.size() > 0) || bt;
      depth = mem ? 5 : ex ? 4 : (id && !redirect_masks_id) ? 3 : 0;
      e_stall = STALL_W'((1 << depth) - 1);
      if (pend_q.size() > 0) begin
        e_busy = 1'b1;
        if (!(mem || ex)) begin
          e_bt = 1'b1; e_flush = 1'b1; e_addr = pend_q.pop_front();
        end
      end else if (bt) begin
        if (!(mem || ex)) begin
          e_bt = 1'b1; e_flush = 1'b1; e_addr = addr;
        end else begin
          pend_q.push_back(addr);
          e_busy = 1'b1;
        end
      end
      if (e_stall[0]) m_stall_cycles++;
      if (e_flush) m_flush_cnt++;
    end
    exp_q.push_back({e_stall, e_flush, e_bt, e_addr, e_busy});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Monitor: one expected record per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e, a;
      e = exp_q.pop_front();
      a = {stall, flush, branch_taken, branch_addr, busy};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle_outputs t=%0t: got stall=%b flush=%b bt=%b addr=%h busy=%b, want stall=%b flush=%b bt=%b addr=%h busy=%b",
                 $time, a[EXP_W-1 -: STALL_W], a[ADDR_W+2], a[ADDR_W+1], a[ADDR_W:1], a[0],
                 e[EXP_W-1 -: STALL_W], e[ADDR_W+2], e[ADDR_W+1], e[ADDR_W:1], e[0]);
      end
    end
  end

  initial begin
    int guard;
    // Boot window with a dropped branch pulse inside it
    cyc(1, 0, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, 1, 32'h55);
    idle(4);
    // Priority
    cyc(0, 1, 1, 0, 0, '0);
    cyc(0, 1, 1, 1, 0, '0);
    idle(1);
    // Unstalled branch
    cyc(0, 0, 0, 0, 1, 32'h40);
    idle(1);
    // Deferred branch under a 3-cycle mem stall, with a second (ignored) pulse
    cyc(0, 0, 0, 1, 1, 32'h100);
    cyc(0, 1, 0, 1, 1, 32'h999);
    cyc(0, 0, 0, 1, 0, '0);
    idle(2);
    // Branch vs load-use
    cyc(0, 1, 0, 0, 1, 32'h80);
    idle(1);
    // Reset while a branch is pending
    cyc(0, 0, 0, 1, 1, 32'h200);
    cyc(0, 0, 0, 1, 0, '0);
    cyc(1, 0, 0, 1, 0, '0);
`ifdef PIPE_CTRL_PERF_EN
    @(posedge clk); #1;
    tests++;
    if (perf_stall_cycles !== '0 || perf_flush_cnt !== '0) begin
      fails++;
      $display("FAIL perf_after_rst: got stall_cycles=%0d flush_cnt=%0d, want 0 and 0",
               perf_stall_cycles, perf_flush_cnt);
    end
`endif
    idle(6);
    // Random traffic
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 4) == 0), ADDR_W'($urandom));
    end
    idle(2);
`ifdef PIPE_CTRL_PERF_EN
    @(posedge clk); #1;
    tests++;
    if (perf_stall_cycles !== CNT_W'(m_stall_cycles) || perf_flush_cnt !== CNT_W'(m_flush_cnt)) begin
      fails++;
      $display("FAIL perf_counts: got stall_cycles=%0d flush_cnt=%0d, want %0d and %0d",
               perf_stall_cycles, perf_flush_cnt, m_stall_cycles, m_flush_cnt);
    end
`endif
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected records left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
